// File: rtl/xor_arbiter_2ch.sv
// Two-channel arbiter sharing one xor_32_bits unit, results queued in a tagged FIFO.
// Define XOR_ARB_RR_EN for round-robin tie-breaking; default is fixed priority (channel 0).

module xor_32_bits (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] y
);
  assign y = a ^ b;
endmodule

module xor_arbiter_2ch #(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          req0_valid,
  output logic                          req0_ready,
  input  logic [31:0]                   req0_a,
  input  logic [31:0]                   req0_b,
  input  logic                          req1_valid,
  output logic                          req1_ready,
  input  logic [31:0]                   req1_a,
  input  logic [31:0]                   req1_b,
  output logic                          res_valid,
  input  logic                          res_ready,
  output logic [31:0]                   res_data,
  output logic                          res_ch,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          busy
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            last_grant_q, last_grant_d;
  logic [32:0]     mem_q [FIFO_DEPTH];

  logic        space;
  logic        tie_grant;
  logic        grant;
  logic        push;
  logic        pop;
  logic [31:0] op_a, op_b, xor_y;
  logic [32:0] head;

  assign space = (count_q < CntW'(FIFO_DEPTH));

  always_comb begin
`ifdef XOR_ARB_RR_EN
    tie_grant = ~last_grant_q;
`else
    // last_grant is tracked in this build but has no say in arbitration.
    tie_grant = 1'b0 & last_grant_q;
`endif
    if (req0_valid && req1_valid) begin
      grant = tie_grant;
    end else begin
      grant = req1_valid & ~req0_valid;
    end
  end

  // Readies held low during reset so nothing is accepted into a FIFO being cleared.
  assign req0_ready = space & ~grant & ~reset;
  assign req1_ready = space & grant & ~reset;

  assign push = (req0_valid & req0_ready) | (req1_valid & req1_ready);
  assign pop  = res_valid & res_ready;

  assign op_a = grant ? req1_a : req0_a;
  assign op_b = grant ? req1_b : req0_b;

  xor_32_bits u_xor (
    .a (op_a),
    .b (op_b),
    .y (xor_y)
  );

  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    last_grant_d = last_grant_q;
    if (push) begin
      wr_ptr_d     = wr_ptr_q + PtrW'(1);
      last_grant_d = grant;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PtrW'(1);
    end
    if (push && !pop) begin
      count_d = count_q + CntW'(1);
    end else if (pop && !push) begin
      count_d = count_q - CntW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      last_grant_q <= 1'b1;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      last_grant_q <= last_grant_d;
    end
  end

  // Storage is not cleared on reset; the pointers alone define occupancy.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {grant, xor_y};
    end
  end

  assign head       = mem_q[rd_ptr_q];
  assign res_valid  = (count_q != '0);
  assign res_data   = res_valid ? head[31:0] : 32'h0;
  assign res_ch     = res_valid ? head[32] : 1'b0;
  assign fifo_count = count_q;
  assign busy       = res_valid;

endmodule

// File: tb/tb_xor_arbiter_2ch.sv
// Self-checking bench for xor_arbiter_2ch: queue-based reference model plus directed vectors.
// Honours XOR_ARB_RR_EN the same way as the design.

module tb_xor_arbiter_2ch;

  localparam int unsigned Depth = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic        res_valid, res_ready;
  logic [31:0] res_data;
  logic        res_ch;
  logic [2:0]  fifo_count;
  logic        busy;

  int checks = 0;
  int errors = 0;
  bit check_en = 1'b0;

  always #5 clk = ~clk;

  xor_arbiter_2ch #(
    .FIFO_DEPTH (Depth)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_data   (res_data),
    .res_ch     (res_ch),
    .fifo_count (fifo_count),
    .busy       (busy)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Reference model: a queue of {channel, result} entries.
  logic [32:0] mq[$];
  int          mlast = 1;

  function automatic int model_grant();
    if (req0_valid && req1_valid) begin
`ifdef XOR_ARB_RR_EN
      return (mlast == 0) ? 1 : 0;
`else
      return 0;
`endif
    end
    return req1_valid ? 1 : 0;
  endfunction

  function automatic bit model_ready(input int ch);
    if (reset) return 1'b0;
    if (mq.size() >= Depth) return 1'b0;
    return model_grant() == ch;
  endfunction

  always @(posedge clk) begin
    int g;
    bit do_push, do_pop;
    if (reset) begin
      mq.delete();
      mlast = 1;
    end else begin
      g       = model_grant();
      do_push = (mq.size() < Depth) && ((g == 0) ? req0_valid : req1_valid);
      do_pop  = (mq.size() != 0) && res_ready;
      if (do_pop) void'(mq.pop_front());
      if (do_push) begin
        mq.push_back({g[0], (g == 1) ? (req1_a ^ req1_b) : (req0_a ^ req0_b)});
        mlast = g;
      end
    end
  end

  always @(negedge clk) begin
    if (check_en) begin
      check("m_count", 32'(fifo_count), 32'(mq.size()));
      check("m_busy", 32'(busy), 32'(mq.size() != 0));
      check("m_res_valid", 32'(res_valid), 32'(mq.size() != 0));
      check("m_res_data", res_data, (mq.size() != 0) ? mq[0][31:0] : 32'h0);
      check("m_res_ch", 32'(res_ch), (mq.size() != 0) ? 32'(mq[0][32]) : 32'h0);
      check("m_req0_ready", 32'(req0_ready), 32'(model_ready(0)));
      check("m_req1_ready", 32'(req1_ready), 32'(model_ready(1)));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic drain();
    idle_inputs();
    res_ready = 1'b1;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (fifo_count == 0) return;
      tick();
    end
    check("drain_timeout", 32'(fifo_count), 32'h0);
  endtask

  initial begin
    int accepts;
    int next_exp;
    int pushed;
    logic [31:0] exp_data;
    logic        exp_ch;

    reset = 1'b1;
    res_ready = 1'b0;
    idle_inputs();
    tick();
    check_en = 1'b1;
    tick();
    @(negedge clk);
    check("rst_count", 32'(fifo_count), 32'h0);
    check("rst_res_valid", 32'(res_valid), 32'h0);
    check("rst_res_data", res_data, 32'h0);
    check("rst_ready0", 32'(req0_ready), 32'h0);
    check("rst_ready1", 32'(req1_ready), 32'h0);
    tick();
    reset = 1'b0;

    // Single transfer, latency and drain
    req0_valid = 1'b1; req0_a = 32'hFFFF0000; req0_b = 32'h0F0F0F0F;
    res_ready = 1'b1;
    @(negedge clk);
    check("t1_ready0", 32'(req0_ready), 32'h1);
    tick();
    req0_valid = 1'b0;
    @(negedge clk);
    check("t1_valid", 32'(res_valid), 32'h1);
    check("t1_data", res_data, 32'hF0F00F0F);
    check("t1_ch", 32'(res_ch), 32'h0);
    check("t1_count", 32'(fifo_count), 32'h1);
    tick();
    @(negedge clk);
    check("t1_count_after", 32'(fifo_count), 32'h0);

    // Contention for 4 cycles from a fresh reset
    tick();
    do_reset();
    req0_valid = 1'b1; req0_a = 32'h1; req0_b = 32'h3;
    req1_valid = 1'b1; req1_a = 32'hA; req1_b = 32'h5;
    res_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (k == 3) idle_inputs();
      @(negedge clk);
`ifdef XOR_ARB_RR_EN
      exp_ch   = k[0];
      exp_data = (k % 2 == 1) ? 32'hF : 32'h2;
`else
      exp_ch   = 1'b0;
      exp_data = 32'h2;
`endif
      check("tie_ch", 32'(res_ch), 32'(exp_ch));
      check("tie_data", res_data, exp_data);
    end
    tick();
    drain();

    // Fill to full with ch1 while the consumer stalls
    tick();
    res_ready = 1'b0;
    req1_valid = 1'b1; req1_a = 32'h100; req1_b = 32'h1;
    accepts = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (req1_valid && req1_ready) accepts++;
      tick();
      req1_a = req1_a + 1;
    end
    @(negedge clk);
    check("full_accepts", 32'(accepts), 32'd4);
    check("full_count", 32'(fifo_count), 32'd4);
    check("full_ready0", 32'(req0_ready), 32'h0);
    check("full_ready1", 32'(req1_ready), 32'h0);
    tick();
    res_ready = 1'b1;
    @(negedge clk);
    check("full_pop_ready1", 32'(req1_ready), 32'h0);
    tick();
    res_ready = 1'b0;
    @(negedge clk);
    check("full_after_pop_ready1", 32'(req1_ready), 32'h1);
    check("full_after_pop_count", 32'(fifo_count), 32'd3);
    tick();
    drain();

    // Ten pushes across a pointer wrap with a toggling consumer
    tick();
    pushed = 0;
    next_exp = 0;
    res_ready = 1'b0;
    req0_valid = 1'b1; req0_a = 32'd0; req0_b = 32'd0;
    for (int n = 0; n < 80 && next_exp < 10; n++) begin
      @(negedge clk);
      check("wrap_max_count", 32'(fifo_count <= 3'd4), 32'h1);
      if (res_valid && res_ready) begin
        check("wrap_order", res_data, 32'(next_exp));
        next_exp++;
      end
      if (req0_valid && req0_ready) pushed++;
      tick();
      res_ready = ~res_ready;
      if (pushed >= 10) begin
        req0_valid = 1'b0;
      end else begin
        req0_a = 32'(pushed);
      end
    end
    check("wrap_popped", 32'(next_exp), 32'd10);
    drain();

    // Reset mid-operation with three entries held
    tick();
    res_ready = 1'b0;
    req0_valid = 1'b1; req0_a = 32'h55; req0_b = 32'h0;
    repeat (3) tick();
    req0_valid = 1'b0;
    @(negedge clk);
    check("mid_count3", 32'(fifo_count), 32'd3);
    tick();
    req0_valid = 1'b1;
    reset = 1'b1;
    @(negedge clk);
    check("mid_rst_ready0", 32'(req0_ready), 32'h0);
    tick();
    reset = 1'b0;
    @(negedge clk);
    check("mid_count0", 32'(fifo_count), 32'h0);
    check("mid_res_valid", 32'(res_valid), 32'h0);
    check("mid_res_data", res_data, 32'h0);
    check("mid_ready0", 32'(req0_ready), 32'h1);
    tick();
    req0_valid = 1'b0;
    @(negedge clk);
    check("mid_accept", 32'(fifo_count), 32'h1);
    check("mid_accept_data", res_data, 32'h55);
    tick();
    drain();

    check_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
